// File: rtl/regfile_dump_unit.sv
// Debug-side register file dumper: walks FIRST_REG..NUM_REGS-1 through a spare read port and streams
// {index, value} beats on a valid/ready interface. Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump_unit #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int FIRST_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_is_sum
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ISSUE, SEND, SUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, SEND, DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [1:0]        LAT_END   = 2'(READ_LAT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lat_cnt;
  logic              at_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  // Walk ends on an ADDR_W-wide equality, so idx never needs to represent NUM_REGS.
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_is_sum = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (lat_cnt == LAT_END) state_nxt = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        if (out_ready) state_nxt = at_last ? SUM : ISSUE;
`else
        out_last = at_last;
        if (out_ready) state_nxt = at_last ? DONE : ISSUE;
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      SUM: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_last   = 1'b1;
        out_is_sum = 1'b1;
        if (out_ready) state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      rf_addr  <= '0;
      lat_cnt  <= '0;
      out_reg  <= '0;
      out_data <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      acc      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= FIRST_IDX;
            rf_addr <= FIRST_IDX;
            lat_cnt <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            acc     <= '0;
`endif
          end
        end
        ISSUE: begin
          if (lat_cnt == LAT_END) begin
            out_data <= rf_data;
            out_reg  <= idx;
            lat_cnt  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            acc      <= acc ^ rf_data;
`endif
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (!at_last) begin
              idx     <= idx + ADDR_W'(1);
              rf_addr <= idx + ADDR_W'(1);
            end
`ifdef REGDUMP_CHECKSUM_EN
            else begin
              out_data <= acc;
              out_reg  <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: three instances (latency/first-register variants) driven from a scenario table,
// each dump compared beat-by-beat against an expected stream built from the register contents.
module tb_regfile_dump_unit;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start[3], busy[3], done[3], out_valid[3], out_ready[3], out_last[3], out_is_sum[3];
  logic [4:0]  rf_addr[3], out_reg[3];
  logic [31:0] rf_data[3], out_data[3];
  logic [31:0] regs[32];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
    logic        last;
    logic        sum;
  } beat_t;

  // mode: 0 ready high, 1 stall on reg 7, 2 second start mid-dump, 3 reset on reg 12, 4 random ready
  // pattern: 0 A000_0000+i, 1 i*3, 2 random, 3 one-hot 1<<i
  typedef struct {
    int dut;
    int mode;
    int pattern;
    int exp_first;
    int exp_cycles;
  } vec_t;

  vec_t vecs[10];

  // Regfile read ports with 1, 3 and 2 cycles of latency respectively.
  logic [31:0] d1_s1, d1_s2, d2_s1;
  assign rf_data[0] = regs[rf_addr[0]];
  always_ff @(posedge clock) begin
    d1_s1 <= regs[rf_addr[1]];
    d1_s2 <= d1_s1;
    d2_s1 <= regs[rf_addr[2]];
  end
  assign rf_data[1] = d1_s2;
  assign rf_data[2] = d2_s1;

  regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .READ_LAT(1), .FIRST_REG(0)) dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rf_addr(rf_addr[0]), .rf_data(rf_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_reg(out_reg[0]), .out_data(out_data[0]), .out_last(out_last[0]), .out_is_sum(out_is_sum[0]));

  regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .READ_LAT(3), .FIRST_REG(0)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rf_addr(rf_addr[1]), .rf_data(rf_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_reg(out_reg[1]), .out_data(out_data[1]), .out_last(out_last[1]), .out_is_sum(out_is_sum[1]));

  regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .READ_LAT(2), .FIRST_REG(1)) dut2 (
    .clock(clock), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .rf_addr(rf_addr[2]), .rf_data(rf_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_reg(out_reg[2]), .out_data(out_data[2]), .out_last(out_last[2]), .out_is_sum(out_is_sum[2]));

  function automatic int first_of(input int d);
    return (d == 2) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill_regs(input int p);
    for (int i = 0; i < 32; i++) begin
      case (p)
        0:       regs[i] = 32'hA000_0000 + 32'(i);
        1:       regs[i] = 32'(i * 3);
        2:       regs[i] = $urandom;
        default: regs[i] = 32'h1 << i;
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d, n, first_n, done_n, done_cnt, stall_left;
    bit stop;
    beat_t got[$], exp[$], b;
    logic [31:0] x;
    d = v.dut;

    x = '0;
    for (int r = first_of(d); r < 32; r++) begin
      b.r = 5'(r); b.v = regs[r]; b.last = (r == 31) && (CK == 0); b.sum = 1'b0;
      exp.push_back(b);
      x ^= regs[r];
    end
    if (CK != 0) begin
      b.r = '0; b.v = x; b.last = 1'b1; b.sum = 1'b1;
      exp.push_back(b);
    end

    @(posedge clock); #1;
    start[d] = 1'b1;
    out_ready[d] = (v.mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clock);
    n = 1;
    #1 start[d] = 1'b0;
    stall_left = 5; first_n = -1; done_n = -1; done_cnt = 0; stop = 1'b0;

    while (!stop) begin
      case (v.mode)
        1: begin
          if (out_valid[d] && out_reg[d] == 5'd7 && stall_left > 0) begin
            out_ready[d] = 1'b0;
            stall_left--;
          end else begin
            out_ready[d] = 1'b1;
          end
        end
        2: start[d] = (n == 10);
        3: begin
          if (out_valid[d] && out_reg[d] == 5'd12) begin
            reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
            @(negedge clock);
            check("rst busy", 64'(busy[d]), 64'd0);
            check("rst out_valid", 64'(out_valid[d]), 64'd0);
            check("rst rf_addr", 64'(rf_addr[d]), 64'd0);
            check("rst out_reg/data/last", {out_reg[d], out_data[d], out_last[d], out_is_sum[d]}, 64'd0);
            for (int k = 0; k < 6; k++) begin
              if (done[d]) done_cnt++;
              @(negedge clock);
            end
            check("rst no done", 64'(done_cnt), 64'd0);
            return;
          end
        end
        4: out_ready[d] = 1'($urandom_range(0, 1));
        default: ;
      endcase

      @(negedge clock);
      if (out_valid[d] && first_n < 0) first_n = n;
      if (out_valid[d] && out_ready[d]) begin
        b.r = out_reg[d]; b.v = out_data[d]; b.last = out_last[d]; b.sum = out_is_sum[d];
        got.push_back(b);
      end
      if (v.mode == 1 && !out_ready[d])
        check("stall hold", {out_valid[d], out_reg[d], out_data[d]}, {1'b1, 5'd7, regs[7]});
      if (done[d]) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n >= 0 && n >= done_n + 3) stop = 1'b1;
      if (n > 3000) stop = 1'b1;
      @(posedge clock);
      n++;
      #1;
    end
    out_ready[d] = 1'b1;

    check("beat count", 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("beat%0d", i), {got[i].r, got[i].v, got[i].last, got[i].sum},
            {exp[i].r, exp[i].v, exp[i].last, exp[i].sum});
    check("done pulses", 64'(done_cnt), 64'd1);
    if (v.exp_first >= 0) check("first valid edge", 64'(first_n), 64'(v.exp_first));
    if (v.exp_cycles >= 0) check("cycles to done", 64'(done_n - 1), 64'(v.exp_cycles));
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    fill_regs(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset busy/done/valid %0d", d), {busy[d], done[d], out_valid[d]}, 64'd0);
      check($sformatf("reset rf_addr %0d", d), 64'(rf_addr[d]), 64'd0);
      check($sformatf("reset out_reg/data %0d", d), {out_reg[d], out_data[d]}, 64'd0);
      check($sformatf("reset last/sum %0d", d), {out_last[d], out_is_sum[d]}, 64'd0);
    end
    @(posedge clock);
    #1 reset = 1'b0;

    vecs[0] = '{0, 0, 0, 2, 32 * 2 + CK};
    vecs[1] = '{0, 1, 0, -1, -1};
    vecs[2] = '{1, 0, 1, 4, 32 * 4 + CK};
    vecs[3] = '{2, 2, 0, 3, 31 * 3 + CK};
    vecs[4] = '{0, 3, 0, -1, -1};
    vecs[5] = '{0, 0, 0, 2, 32 * 2 + CK};
    vecs[6] = '{0, 0, 3, 2, 32 * 2 + CK};
    vecs[7] = '{0, 4, 2, -1, -1};
    vecs[8] = '{1, 4, 2, -1, -1};
    vecs[9] = '{2, 4, 2, -1, -1};

    for (int i = 0; i < 10; i++) begin
      fill_regs(vecs[i].pattern);
      run_vec(vecs[i]);
      repeat (2) @(posedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
